shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one combinational shift datapath (`Shift_Unit`) between two requesters:
- requester 0, the integer execute stage, has priority at reset;
- requester 1 is the auxiliary (CSR/microcode) port.

The block provides a valid/ready request and response handshake, round-robin arbitration, registered operands and a registered result with an error flag. It sits between the issue logic and the shifter, so neither requester drives the datapath directly.

## Interface
- `XLEN`, default 32: operand and result width.
- `CLK`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort; discards in-flight op and any pending response.
- `reqN_valid`  in  1  request from requester N (N = 0, 1).
- `reqN_ready`  out  1  request accepted this cycle.
- `reqN_src1`  in  XLEN  operand to shift.
- `reqN_src2`  in  5  shift amount.
- `reqN_funct3_2`  in  1  op select bit.
- `reqN_funct7_5`  in  1  op select bit.
- `respN_valid`  out  1  result available for requester N.
- `respN_ready`  in  1  requester N takes the result.
- `resp_result`  out  XLEN  result, shared by both response channels.
- `resp_err`  out  1  the op code was illegal.

## Operation
- Op code is `{funct7_5, funct3_2}`:
  - 00 = SLL;
  - 01 = SRL;
  - 11 = SRA;
  - 10 = illegal: result 0, `resp_err` = 1.
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: registered operands drive the shifter, with En = 1. Unconditionally goes to RESP next edge; result, error flag and owner are captured at that edge.
  - RESP: `respN_valid` is high for the owner only, until `respN_ready`.
- `can_accept` = IDLE, or RESP with the owner's `resp_ready` high in the same cycle (back-to-back).
- Arbitration:
  - The grant is computed from the valids and the priority pointer only. It never depends on `resp_ready`, except through `can_accept`.
  - `reqN_ready` = `can_accept` && grant==N.
  - Single valid: that requester is granted.
  - Both valid: the requester the pointer names is granted.
  - On each accept, the pointer moves to the non-granted requester.
- Accept: capture src1, src2, op, owner and the legality check into operand registers, then go to EXEC.
- RESP with handshake and no new accept goes to IDLE.
- The shifter enable is low outside EXEC.
- Requesters must hold valid and operands stable until ready. The block does not check this.
- `flush`:
  - next state is IDLE from any state;
  - response valids drop;
  - the pointer is unchanged;
  - a request presented in the flush cycle is not accepted (`reqN_ready` = 0 while `flush`=1).
- Reset (async, any state):
  - state IDLE, pointer 0;
  - all `reqN_ready` and `respN_valid` 0;
  - `resp_result` 0, `resp_err` 0;
  - operand registers 0.

## Timing
- Request accepted in cycle N. EXEC is cycle N+1. `respN_valid` is high from cycle N+2.
- Minimum request latency is 2 cycles.
- Sustained throughput is 1 op per 2 cycles, using back-to-back accept in RESP.
- `resp_result` and `resp_err` stay stable while `respN_valid` is high and not taken. They are don't-care otherwise, but implemented as a hold of the last value.
- `reqN_ready` is combinational from the valids, `respN_ready`, state, pointer and flush. It has no dependence on `reqN_src*`.
- Response outputs are registered only; there is no combinational path from any input.

## Structure
- A shared package holds:
  - the op-code localparams (SLL=2'b00, SRL=2'b01, SRA=2'b11);
  - the FSM state encoding (IDLE, EXEC, RESP);
  - the requester count localparam (2).
- One sub-module: the existing `Shift_Unit` instance, with En = (state==EXEC).
- The legality check is local to this block.

## Test plan
- Reset, then req0 SLL src1=0x0000_0001 src2=31 -> `req0_ready` in cycle 0; `resp0_valid` in cycle 2 with result 0x8000_0000, err 0.
- Both valid at once:
  - req0 SRA 0x8000_0000 by 4 and req1 SRL 0x8000_0000 by 4, with `resp_ready` held high;
  - expect req0 served first -> 0xF800_0000;
  - expect req1 accepted back-to-back in the req0 response cycle -> 0x0800_0000;
  - a subsequent simultaneous pair is served req0 first again (pointer at 0).
- Backpressure: `resp1_ready` held low 5 cycles after `resp1_valid` -> result held stable, both `reqN_ready` low; then `resp1_ready` high -> IDLE next cycle.
- Illegal op `{1,0}`, src1=0xFFFF_FFFF -> result 0x0000_0000, `resp_err` = 1.
- `flush` in the EXEC cycle -> no `respN_valid` ever asserted; IDLE next cycle; a new request is accepted the cycle after flush deasserts.
- `rst_n` asserted asynchronously mid-RESP -> `respN_valid` and all outputs 0 immediately; after release, the pointer favours req0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter slice.
//   - op-code encodings for {funct7_5, funct3_2}
//   - FSM state encoding
//   - requester count, shift-amount width, per-request command struct
//   - legality helper for op codes
package shift_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_ILL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Operand-independent part of a request.
  typedef struct packed {
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;     // {funct7_5, funct3_2}
  } shift_cmd_t;

  function automatic logic op_legal(input logic [1:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/shift_arbiter_shift_unit.sv
// Shift_Unit: shared combinational shifter.
//   En     in   1        datapath enable; output forced to 0 when low
//   op     in   2        {funct7_5, funct3_2}: SLL / SRL / SRA, other -> 0
//   src    in   XLEN     value to shift
//   shamt  in   SHAMT_W  shift amount
//   result out  XLEN     shifted value
module Shift_Unit
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               En,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    src,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    result
);

  always_comb begin
    result = '0;
    if (En) begin
      case (op)
        OP_SLL:  result = src << shamt;
        OP_SRL:  result = src >> shamt;
        OP_SRA:  result = $signed(src) >>> shamt;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one Shift_Unit.
// Requester 0 (integer execute) has priority out of reset, requester 1 is
// the auxiliary port. Round-robin grant, operands registered on accept,
// result/error registered on the EXEC->RESP edge.
//   CLK, rst_n            clock, async active-low reset
//   flush                 synchronous abort of in-flight op / pending response
//   reqN_valid/ready      request handshake (ready is combinational)
//   reqN_src1/src2        operand and shift amount
//   reqN_funct3_2/7_5     op select bits
//   respN_valid/ready     response handshake, valid only for the owner
//   resp_result/resp_err  shared registered result and illegal-op flag
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_src1,
  input  logic [SHAMT_W-1:0] req0_src2,
  input  logic               req0_funct3_2,
  input  logic               req0_funct7_5,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_src1,
  input  logic [SHAMT_W-1:0] req1_src2,
  input  logic               req1_funct3_2,
  input  logic               req1_funct7_5,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [XLEN-1:0]    resp_result,
  output logic               resp_err
);

  // Per-requester views of the flat ports.
  logic       [NUM_REQ-1:0]           req_valid, req_ready;
  logic       [NUM_REQ-1:0]           resp_valid, resp_ready;
  logic       [NUM_REQ-1:0][XLEN-1:0] req_src1;
  shift_cmd_t [NUM_REQ-1:0]           req_cmd;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_src1   = {req1_src1, req0_src1};
  assign req_cmd[0] = '{shamt: req0_src2, op: {req0_funct7_5, req0_funct3_2}};
  assign req_cmd[1] = '{shamt: req1_src2, op: {req1_funct7_5, req1_funct3_2}};

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];

  state_t            state_q, state_d;
  logic              ptr_q;        // requester favoured when both are valid
  logic              grant, any_valid, can_accept, accept;

  logic [XLEN-1:0]   op_src1_q;
  shift_cmd_t        op_cmd_q;
  logic              op_owner_q, op_illegal_q;
  logic              resp_owner_q;

  logic              shift_en;
  logic [XLEN-1:0]   shift_y;

  // Grant looks only at valids and the pointer; resp_ready enters solely
  // through can_accept, so a stalled response never reshuffles the grant.
  always_comb begin
    any_valid = |req_valid;
    if (&req_valid) grant = ptr_q;
    else            grant = req_valid[1];
  end

  // RESP may hand over directly to the next op when the owner takes its
  // result in the same cycle, giving 1 op / 2 cycles sustained.
  assign can_accept = (state_q == ST_IDLE) ||
                      ((state_q == ST_RESP) && resp_ready[resp_owner_q]);
  assign accept     = rst_n && !flush && can_accept && any_valid;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_EXEC;
        ST_EXEC: state_d = ST_RESP;
        ST_RESP: begin
          if (accept)                         state_d = ST_EXEC;
          else if (resp_ready[resp_owner_q])  state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (accept)              req_ready[grant]         = 1'b1;
    if (state_q == ST_RESP)  resp_valid[resp_owner_q] = 1'b1;
  end

  assign shift_en = (state_q == ST_EXEC);

  // Operand capture and pointer rotation on accept. Flush blocks accept,
  // so it leaves the pointer untouched.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      op_src1_q    <= '0;
      op_cmd_q     <= '0;
      op_owner_q   <= 1'b0;
      op_illegal_q <= 1'b0;
      ptr_q        <= 1'b0;
    end else if (accept) begin
      op_src1_q    <= req_src1[grant];
      op_cmd_q     <= req_cmd[grant];
      op_owner_q   <= grant;
      op_illegal_q <= !op_legal(req_cmd[grant].op);
      ptr_q        <= ~grant;
    end
  end

  // Result capture at the end of EXEC. Owner is copied separately from the
  // operand owner because a back-to-back accept overwrites the operands
  // while the previous response is still being presented.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      resp_result  <= '0;
      resp_err     <= 1'b0;
      resp_owner_q <= 1'b0;
    end else if (shift_en && !flush) begin
      resp_result  <= op_illegal_q ? '0 : shift_y;
      resp_err     <= op_illegal_q;
      resp_owner_q <= op_owner_q;
    end
  end

  Shift_Unit #(.XLEN(XLEN)) u_shift (
    .En     (shift_en),
    .op     (op_cmd_q.op),
    .src    (op_src1_q),
    .shamt  (op_cmd_q.shamt),
    .result (shift_y)
  );

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed handshake/arbitration/flush/reset steps
// followed by randomized rounds checked against a transaction-level model
// (expected results from plain arithmetic, grant order from the pointer rule,
// in-flight ops kept in queues).
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n, flush;
  logic [1:0]  rv, rdy, pv, pr;
  logic [31:0] s1 [2];
  logic [4:0]  s2 [2];
  logic [1:0]  opc [2];
  logic [31:0] resp_result;
  logic        resp_err;

  int errors = 0, checks = 0, cyc = 0;
  int mptr, g, budget, lat;
  logic [1:0]  m;
  logic [31:0] a0, a1, a2, e1;
  logic [4:0]  h0, h1, h2;
  bit          front_seen, taken, acc;
  int          q_own[$], q_cyc[$];
  logic [31:0] q_res[$];
  logic        q_err[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  shift_arbiter #(.XLEN(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_src1(s1[0]), .req0_src2(s2[0]),
    .req0_funct3_2(opc[0][0]), .req0_funct7_5(opc[0][1]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_src1(s1[1]), .req1_src2(s2[1]),
    .req1_funct3_2(opc[1][0]), .req1_funct7_5(opc[1][1]),
    .resp0_valid(pv[0]), .resp0_ready(pr[0]),
    .resp1_valid(pv[1]), .resp1_ready(pr[1]),
    .resp_result(resp_result), .resp_err(resp_err)
  );

  // Expected shift result by arithmetic: multiply / floor-divide by 2**sh.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    logic [63:0] ua, d;
    longint      v, sd;
    ua = {32'd0, a};
    d  = 64'd1 << sh;
    sd = longint'(d);
    case (op)
      2'b00: return ua[31:0] * d[31:0];
      2'b01: return 32'(ua / d);
      2'b11: begin
        v = a[31] ? longint'(ua) - 64'sd4294967296 : longint'(ua);
        if (v < 0) v = (v - (sd - 1)) / sd;
        else       v = v / sd;
        return 32'(v);
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int n, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh);
    rv[n] = 1'b1; opc[n] = op; s1[n] = a; s2[n] = sh;
  endtask

  // Single request from an idle block: ready at once, response 2 cycles later.
  task automatic run_single(input int n, input logic [1:0] op, input logic [31:0] a,
                            input logic [4:0] sh);
    drive(n, op, a, sh);
    pr[n] = 1'b0;
    #1;
    chk($sformatf("single%0d_rdy", n), rdy, 32'(1) << n);
    step;
    rv[n] = 1'b0;
    for (lat = 1; lat < 10 && !pv[n]; lat++) step;
    chk($sformatf("single%0d_lat", n), lat, 2);
    chk($sformatf("single%0d_res", n), resp_result, ref_shift(op, a, sh));
    chk($sformatf("single%0d_err", n), resp_err, (op == 2'b10));
    pr[n] = 1'b1;
    step;
    pr[n] = 1'b0;
    chk($sformatf("single%0d_drop", n), pv, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rv = 2'b11; pr = 2'b00;
    for (int n = 0; n < 2; n++) begin s1[n] = '0; s2[n] = '0; opc[n] = '0; end

    // Reset state, with both requesters asserting valid.
    step; step;
    chk("rst_rdy", rdy, 0);
    chk("rst_pv", pv, 0);
    chk("rst_res", resp_result, 0);
    chk("rst_err", resp_err, 0);
    rv = 2'b00;
    rst_n = 1'b1;
    step;

    // First op: SLL 1 by 31. Then a req1 op so the pointer returns to 0.
    run_single(0, 2'b00, 32'h0000_0001, 5'd31);
    chk("sll31_res", resp_result, 32'h8000_0000);
    run_single(1, 2'b01, 32'hDEAD_BEEF, 5'd12);

    // Simultaneous pair, responses always taken: req0 then req1 back-to-back.
    pr = 2'b11;
    drive(0, 2'b11, 32'h8000_0000, 5'd4);
    drive(1, 2'b01, 32'h8000_0000, 5'd4);
    #1 chk("pair_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    #1 chk("pair_exec_rdy", rdy, 2'b00);
    chk("pair_exec_pv", pv, 2'b00);
    step;
    chk("pair_pv0", pv, 2'b01);
    chk("pair_res0", resp_result, 32'hF800_0000);
    chk("pair_b2b_rdy", rdy, 2'b10);
    step; rv[1] = 1'b0;
    chk("pair_exec2_pv", pv, 2'b00);
    step;
    chk("pair_pv1", pv, 2'b10);
    chk("pair_res1", resp_result, 32'h0800_0000);
    step;
    chk("pair_idle_pv", pv, 2'b00);

    // Second pair (pointer back at 0), then backpressure on resp1 while req0 waits.
    pr = 2'b01;
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    h0 = 5'($urandom_range(0, 31)); h1 = 5'($urandom_range(0, 31)); h2 = 5'($urandom_range(0, 31));
    drive(0, 2'b00, a0, h0);
    drive(1, 2'b11, a1, h1);
    #1 chk("pair2_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    step;
    chk("pair2_pv0", pv, 2'b01);
    chk("pair2_res0", resp_result, ref_shift(2'b00, a0, h0));
    chk("pair2_b2b_rdy", rdy, 2'b10);
    step; rv[1] = 1'b0;
    drive(0, 2'b01, a2, h2);
    step;
    e1 = ref_shift(2'b11, a1, h1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_pv", pv, 2'b10);
      chk("stall_res", resp_result, e1);
      chk("stall_err", resp_err, 0);
      chk("stall_rdy", rdy, 2'b00);
      step;
    end
    pr = 2'b11;
    #1 chk("release_rdy", rdy, 2'b01);
    chk("release_pv", pv, 2'b10);
    step; rv[0] = 1'b0;
    chk("release_exec_pv", pv, 2'b00);
    step;
    chk("release_pv0", pv, 2'b01);
    chk("release_res0", resp_result, ref_shift(2'b01, a2, h2));
    step;
    pr = 2'b00;
    chk("release_idle_pv", pv, 2'b00);

    // Illegal op through req1, accepted straight from idle.
    run_single(1, 2'b10, 32'hFFFF_FFFF, 5'($urandom_range(0, 31)));
    chk("ill_res", resp_result, 32'h0000_0000);
    chk("ill_err", resp_err, 1);

    // Flush in EXEC: the op vanishes, flush blocks accept, pointer unchanged.
    drive(0, 2'b00, 32'h1234_5678, 5'd3);
    #1 chk("fl_acc_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    flush = 1'b1;
    drive(1, 2'b01, 32'hF0F0_0000, 5'd8);
    #1 chk("fl_exec_rdy", rdy, 2'b00);
    step;
    chk("fl_pv_a", pv, 2'b00);
    chk("fl_idle_rdy", rdy, 2'b00);
    step;
    flush = 1'b0;
    chk("fl_pv_b", pv, 2'b00);
    drive(0, 2'b11, 32'h8000_00F0, 5'd4);
    pr = 2'b11;
    #1 chk("fl_after_rdy", rdy, 2'b10);
    step; rv[1] = 1'b0;
    chk("fl_exec_pv", pv, 2'b00);
    step;
    chk("fl_pv1", pv, 2'b10);
    chk("fl_res1", resp_result, 32'h00F0_F000);
    chk("fl_b2b_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    step;
    chk("fl_pv0", pv, 2'b01);
    chk("fl_res0", resp_result, 32'hF800_000F);
    step;
    pr = 2'b00;

    // Async reset in the middle of a held response; pointer was at 1.
    drive(0, 2'b00, 32'hA5A5_A5A5, 5'd1);
    #1 chk("ar_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    step;
    chk("ar_pv", pv, 2'b01);
    chk("ar_res", resp_result, 32'h4B4B_4B4A);
    #2 rst_n = 1'b0;
    drive(0, 2'b01, 32'hFFFF_0000, 5'd16);
    drive(1, 2'b00, 32'h0000_FFFF, 5'd16);
    #1;
    chk("ar_in_pv", pv, 2'b00);
    chk("ar_in_rdy", rdy, 2'b00);
    chk("ar_in_res", resp_result, 0);
    chk("ar_in_err", resp_err, 0);
    #1 rst_n = 1'b1;
    pr = 2'b11;
    #1 chk("ar_after_rdy", rdy, 2'b01);
    step; rv[0] = 1'b0;
    step;
    chk("ar_pv0", pv, 2'b01);
    chk("ar_res0", resp_result, 32'h0000_FFFF);
    step; rv[1] = 1'b0;
    step;
    chk("ar_pv1", pv, 2'b10);
    chk("ar_res1", resp_result, 32'hFFFF_0000);
    step;
    pr = 2'b00;

    // Fresh reset so the model pointer starts at 0, then random rounds.
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    mptr = 0;
    for (int r = 0; r < 40; r++) begin
      m = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++)
        if (m[n]) drive(n, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
      budget = 0;
      front_seen = 0;
      while ((rv != 2'b00 || q_own.size() != 0) && budget < 40) begin
        pr = 2'($urandom_range(0, 3));
        #1;
        taken = 0;
        if (pv != 2'b00) begin
          if (q_own.size() == 0) begin
            chk("rnd_spurious_pv", pv, 0);
          end else begin
            chk("rnd_owner", pv, 32'(1) << q_own[0]);
            if (!front_seen) chk("rnd_lat", cyc - q_cyc[0], 2);
            front_seen = 1;
            chk("rnd_res", resp_result, q_res[0]);
            chk("rnd_err", resp_err, q_err[0]);
            taken = pr[q_own[0]];
          end
        end
        acc = 0;
        if (rdy != 2'b00) begin
          g = (rv == 2'b11) ? mptr : (rv[1] ? 1 : 0);
          chk("rnd_grant", rdy, (rv == 2'b00) ? 0 : (32'(1) << g));
          chk("rnd_slot", (q_own.size() == 0) || taken, 1);
          mptr = 1 - g;
          q_own.push_back(g);
          q_cyc.push_back(cyc);
          q_res.push_back(ref_shift(opc[g], s1[g], s2[g]));
          q_err.push_back(opc[g] == 2'b10);
          acc = 1;
        end
        if (taken) begin
          void'(q_own.pop_front()); void'(q_cyc.pop_front());
          void'(q_res.pop_front()); void'(q_err.pop_front());
          front_seen = 0;
        end
        step;
        budget++;
        if (acc) rv[g] = 1'b0;
      end
      chk("rnd_drain", (rv == 2'b00) && (q_own.size() == 0), 1);
      if (rv != 2'b00 || q_own.size() != 0) break;
      pr = 2'b00;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
